signed_minmax_tracker: RTL and testbench
========================================

Name: signed_minmax_tracker

Overview:
- Downstream consumer of the 4-bit signed three-way comparison (greater/equal/less, sign bit checked before magnitude).
- Accepts a stream of signed two's-complement samples grouped into frames.
- Tracks the running minimum, running maximum and sample count per frame.
- Presents a registered result on a valid/ready output handshake when the frame closes.

Parameters:
- DATA_W, 4, sample width in bits, two's complement, MSB is sign.
- CNT_W, 4, width of the per-frame sample counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  signed sample.
- in_last  input  1  qualifies in_data as the final sample of the frame.
- out_valid  output  1  frame result available.
- out_ready  input  1  downstream takes the result.
- out_min  output  DATA_W  smallest signed sample of the frame.
- out_max  output  DATA_W  largest signed sample of the frame.
- out_count  output  CNT_W  number of samples in the frame, saturating.
- out_ovf  output  1  frame held more than 2^CNT_W-1 samples.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low (rst_n).
- Reset state: state=IDLE, in_ready=1, out_valid=0, out_min=0, out_max=0, out_count=0, out_ovf=0. All outputs are registered.
- Accept condition: accept = in_valid & in_ready.
- Comparison rule, for sample S against stored value R:
  - S sign 1 and R sign 0: S < R.
  - S sign 0 and R sign 1: S > R.
  - Equal signs: unsigned compare of the full DATA_W bits.
- Ties: on S == R, no update (the earlier sample is kept).
- State IDLE (no frame open), on accept:
  - min <= in_data, max <= in_data, count <= 1, ovf <= 0.
  - If in_last: go to HOLD. Otherwise: go to ACCUM.
- State ACCUM, on accept:
  - min <= in_data if S < min; max <= in_data if S > max.
  - count <= count+1, saturating at all-ones; ovf <= 1 if count was already all-ones.
  - If in_last: go to HOLD.
  - No accept: hold all values.
- State HOLD:
  - in_ready=0, out_valid=1; out_min/out_max/out_count/out_ovf stay stable.
  - On out_valid & out_ready: go to IDLE; out_valid falls the next cycle.
  - in_ready returns to 1 the cycle after the output handshake, giving exactly one bubble. There is no bypass from HOLD straight into a new frame.
- Latency: out_valid asserts the cycle after the in_last sample is accepted.
- Single-sample frame (in_last on the first sample): out_min = out_max = that sample, out_count = 1.
- in_valid while in_ready=0: ignored. Upstream must hold the sample until it is accepted.
- in_last without in_valid: ignored.
- out_min/out_max track the running values in ACCUM. They are meaningful only while out_valid=1.
- Reset asserted mid-frame or in HOLD: everything returns to reset values immediately; the partial frame is discarded.
- X on in_data with in_valid=0: must not affect state.

Optional Feature:
- Macro: MINMAX_IDX_EN.
- When defined:
  - Adds outputs out_min_idx and out_max_idx, each CNT_W wide, registered.
  - Each gives the 0-based position in the frame of the sample that set min/max; ties keep the earlier position.
  - Both are set to 0 on the first sample and on reset.
  - They saturate with the counter: once the count has saturated, later updates record all-ones.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Frame 4'b0011 (+3), 4'b1110 (-2), 4'b0111 (+7, last) -> out_valid the cycle after the last accept; out_min=4'hE, out_max=4'h7, out_count=3, out_ovf=0. With MINMAX_IDX_EN: min_idx=1, max_idx=2.
- Extremes: frame 4'h0, 4'h8 (-8), 4'h7 (+7), 4'hF (-1, last) -> min=4'h8, max=4'h7, count=4. This proves the sign-first compare: unsigned ordering would give min=0, max=F.
- Single sample 4'h5 with in_last, out_ready held low for 5 cycles -> out_valid stays 1 with min=max=4'h5, count=1, in_ready=0 throughout. Raise out_ready -> out_valid=0 and in_ready=1 on the following cycle.
- Overflow: 17 samples of 4'h1, last on the 17th -> out_count=4'hF, out_ovf=1. A following 2-sample frame (4'h2, 4'h3) -> count=2, ovf=0, min=2, max=3.
- Ties and gaps: frame 4'hC, 4'hC, 4'hC with in_valid deasserted between samples -> min=max=4'hC, count=3. With MINMAX_IDX_EN: both indices 0.
- Reset mid-frame: two samples accepted, then rst_n pulsed low asynchronously (not clock-aligned) -> all outputs 0 at once, in_ready=1. A new frame 4'h2 (last) -> min=max=2, count=1.

Source files
------------

// File: rtl/signed_minmax_tracker.sv
// Per-frame running signed min/max and saturating sample count, presented on a registered valid/ready result.
// Optional: define MINMAX_IDX_EN to also report the in-frame positions of the min and max samples.
module signed_minmax_tracker #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_min,
   output logic [DATA_W-1:0] out_max,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
`ifdef MINMAX_IDX_EN
   ,
   output logic [CNT_W-1:0]  out_min_idx,
   output logic [CNT_W-1:0]  out_max_idx
`endif
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state;
   logic             accept;
   logic             count_full;
   logic [CNT_W-1:0] count_next;

   assign accept     = in_valid & in_ready;
   assign count_full = (out_count == '1);
   assign count_next = count_full ? out_count : out_count + CNT_W'(1);

   // Sign bit decides first; equal signs fall back to an unsigned compare of all bits.
   function automatic logic is_less(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] r);
      if (s[DATA_W-1] != r[DATA_W-1]) return s[DATA_W-1];
      return s < r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_min   <= '0;
         out_max   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
`ifdef MINMAX_IDX_EN
         out_min_idx <= '0;
         out_max_idx <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  out_min   <= in_data;
                  out_max   <= in_data;
                  out_count <= CNT_W'(1);
                  out_ovf   <= 1'b0;
`ifdef MINMAX_IDX_EN
                  out_min_idx <= '0;
                  out_max_idx <= '0;
`endif
                  if (in_last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  // The pre-increment count is this sample's position, already saturated.
                  if (is_less(in_data, out_min)) begin
                     out_min <= in_data;
`ifdef MINMAX_IDX_EN
                     out_min_idx <= out_count;
`endif
                  end
                  if (is_less(out_max, in_data)) begin
                     out_max <= in_data;
`ifdef MINMAX_IDX_EN
                     out_max_idx <= out_count;
`endif
                  end
                  out_count <= count_next;
                  if (count_full) out_ovf <= 1'b1;
                  if (in_last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Scoreboard bench for signed_minmax_tracker: frames are modelled with plain signed arithmetic and
// checked by an independent monitor at each output handshake. Define MINMAX_IDX_EN to check indices.
module tb_signed_minmax_tracker;

   localparam int DATA_W = 4;
   localparam int CNT_W  = 4;

   typedef logic [3:0] sampq_t[$];
   typedef struct packed {
      logic [3:0] mn;
      logic [3:0] mx;
      logic [3:0] cnt;
      logic       ovf;
      logic [3:0] mni;
      logic [3:0] mxi;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = 4'h0;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_min;
   logic [3:0] out_max;
   logic [3:0] out_count;
   logic       out_ovf;
`ifdef MINMAX_IDX_EN
   logic [3:0] out_min_idx;
   logic [3:0] out_max_idx;
`endif

   exp_t       expQ[$];
   logic [3:0] frameQ[$];
   int         vectors = 0;
   int         miscompares = 0;
   bit         readyRandom = 1'b1;
   logic       readyForce = 1'b1;

   signed_minmax_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_min(out_min),
      .out_max(out_max),
      .out_count(out_count),
      .out_ovf(out_ovf)
`ifdef MINMAX_IDX_EN
      ,
      .out_min_idx(out_min_idx),
      .out_max_idx(out_max_idx)
`endif
   );

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: first occurrence of the signed extreme wins; positions and count saturate at 15.
   task automatic pushExpected();
      exp_t e;
      int   n;
      n     = frameQ.size();
      e.mn  = frameQ[0];
      e.mx  = frameQ[0];
      e.mni = 4'h0;
      e.mxi = 4'h0;
      for (int i = 1; i < n; i++) begin
         if ($signed(frameQ[i]) < $signed(e.mn)) begin
            e.mn  = frameQ[i];
            e.mni = (i > 15) ? 4'hF : 4'(i);
         end
         if ($signed(frameQ[i]) > $signed(e.mx)) begin
            e.mx  = frameQ[i];
            e.mxi = (i > 15) ? 4'hF : 4'(i);
         end
      end
      e.cnt = (n > 15) ? 4'hF : 4'(n);
      e.ovf = (n > 15);
      expQ.push_back(e);
   endtask

   task automatic sendSample(input logic [3:0] d, input bit last, output bit ok);
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 'x;
   endtask

   task automatic applyStimulus(input sampq_t samples, input int minGap, input int maxGap);
      bit ok;
      bit allOk;
      int gaps;
      allOk = 1'b1;
      frameQ.delete();
      for (int i = 0; i < samples.size(); i++) begin
         gaps = $urandom_range(maxGap, minGap);
         // Idle cycles carry junk data and a stray in_last that must be ignored.
         repeat (gaps) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(1, 0));
            in_data  = 4'($urandom);
            @(posedge clk);
            #1;
         end
         in_last = 1'b0;
         sendSample(samples[i], i == samples.size() - 1, ok);
         allOk = allOk & ok;
         frameQ.push_back(samples[i]);
      end
      pushExpected();
      if (allOk) begin
         @(negedge clk);
         checkOutput("latency_valid", 32'(out_valid), 32'd1);
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 500 && (expQ.size() != 0 || out_valid); c++) @(posedge clk);
      if (expQ.size() != 0 || out_valid) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
      #1;
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = readyRandom ? ($urandom_range(3, 0) != 0) : readyForce;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("out_min", 32'(out_min), 32'(e.mn));
               checkOutput("out_max", 32'(out_max), 32'(e.mx));
               checkOutput("out_count", 32'(out_count), 32'(e.cnt));
               checkOutput("out_ovf", 32'(out_ovf), 32'(e.ovf));
`ifdef MINMAX_IDX_EN
               checkOutput("out_min_idx", 32'(out_min_idx), 32'(e.mni));
               checkOutput("out_max_idx", 32'(out_max_idx), 32'(e.mxi));
`endif
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_out_min"}, 32'(out_min), 32'd0);
      checkOutput({tag, "_out_max"}, 32'(out_max), 32'd0);
      checkOutput({tag, "_out_count"}, 32'(out_count), 32'd0);
      checkOutput({tag, "_out_ovf"}, 32'(out_ovf), 32'd0);
`ifdef MINMAX_IDX_EN
      checkOutput({tag, "_min_idx"}, 32'(out_min_idx), 32'd0);
      checkOutput({tag, "_max_idx"}, 32'(out_max_idx), 32'd0);
`endif
   endtask

   initial begin
      sampq_t s;
      bit     ok;
      int     len;

      repeat (3) @(posedge clk);
      #3;
      checkResetState("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      s = {4'h3, 4'hE, 4'h7};
      applyStimulus(s, 0, 0);
      s = {4'h0, 4'h8, 4'h7, 4'hF};
      applyStimulus(s, 0, 2);
      drain();

      // Single-sample frame held against a stalled consumer.
      readyRandom = 1'b0;
      readyForce  = 1'b0;
      s = {4'h5};
      applyStimulus(s, 0, 0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
         checkOutput("hold_out_min", 32'(out_min), 32'h5);
         checkOutput("hold_out_max", 32'(out_max), 32'h5);
         checkOutput("hold_out_count", 32'(out_count), 32'd1);
      end
      readyForce = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("release_out_valid", 32'(out_valid), 32'd0);
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);
      readyRandom = 1'b1;
      @(posedge clk);
      #1;

      s = {};
      repeat (17) s.push_back(4'h1);
      applyStimulus(s, 0, 1);
      s = {4'h2, 4'h3};
      applyStimulus(s, 0, 1);
      s = {4'hC, 4'hC, 4'hC};
      applyStimulus(s, 1, 3);

      for (int f = 0; f < 25; f++) begin
         len = $urandom_range(20, 1);
         s = {};
         for (int k = 0; k < len; k++) s.push_back(4'($urandom));
         applyStimulus(s, 0, 2);
      end
      drain();

      // Asynchronous reset in the middle of a frame discards it.
      sendSample(4'h4, 1'b0, ok);
      sendSample(4'hA, 1'b0, ok);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetState("midreset");
      #7;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      s = {4'h2};
      applyStimulus(s, 0, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
